multdiv_ctrl: RTL and testbench
===============================

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ctrl_mult  in  1  multiply start request, sampled each edge.
REQ-005 ctrl_div  in  1  divide start request, sampled each edge.
REQ-006 div_zero  in  1  divisor-is-zero flag, meaningful only in the cycle ctrl_div is high.
REQ-007 ct  in  5  current count from the 32-step counter.
REQ-008 c_end  in  1  counter-at-31 flag from the 32-step counter.
REQ-009 cnt_reset  out  1  reset drive to the 32-step counter.
REQ-010 load  out  1  operand-register load strobe for the datapath.
REQ-011 step_en  out  1  datapath iteration enable.
REQ-012 first_step  out  1  high when step_en is high and ct is 0.
REQ-013 is_div  out  1  latched operation: 1 means divide, 0 means multiply.
REQ-014 busy  out  1  high while in LOAD or RUN.
REQ-015 result_rdy  out  1  one-cycle completion pulse.
REQ-016 exception  out  1  error flag, only ever high together with result_rdy.
REQ-017 timeout  out  1  watchdog flag, only ever high together with exception (see Configuration).

Function
REQ-018 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE; all outputs SHALL be decoded from state, ct and c_end only.
REQ-019 A start is defined as exactly one of ctrl_mult or ctrl_div being high, sampled in any state.
- On a start the next state SHALL be LOAD.
- is_div SHALL latch ctrl_div on that same edge.
REQ-020 If ctrl_mult and ctrl_div are both high, the block SHALL enter DONE with exception=1; is_div SHALL be unchanged.
REQ-021 If ctrl_div=1, ctrl_mult=0 and div_zero=1, the block SHALL set is_div=1 and enter DONE with exception=1, skipping LOAD and RUN.
REQ-022 cnt_reset SHALL be 1 in IDLE, LOAD and DONE, and 0 in RUN.
REQ-023 LOAD SHALL last exactly one cycle with load=1, then go to RUN.
REQ-024 In RUN, step_en SHALL be 1 on every cycle.
- RUN SHALL exit to DONE on the edge where c_end=1, giving exactly 32 step_en cycles with ct counting 0..31.
REQ-025 DONE SHALL last one cycle with result_rdy=1, then go to IDLE; a start sampled in DONE SHALL go to LOAD instead.
REQ-026 Latency: a start sampled at edge T SHALL produce load in cycle T+1, step_en in cycles T+2..T+33, and result_rdy in cycle T+34.
REQ-027 A start sampled during LOAD or RUN SHALL abort the current operation and go to LOAD with the new operation; no result_rdy SHALL be issued for the aborted operation.
REQ-028 c_end seen in IDLE, LOAD or DONE SHALL be ignored.
REQ-029 ct is not checked for monotonicity; only c_end ends RUN.
REQ-030 exception SHALL be a registered flag that is cleared when the block leaves DONE.

Reset
REQ-031 reset SHALL take priority over every other input.
REQ-032 On reset the block SHALL set state=IDLE, is_div=0, exception=0, timeout=0, result_rdy=0, load=0, step_en=0, busy=0, and cnt_reset=1.
REQ-033 A reset during LOAD or RUN SHALL abandon the operation with no result_rdy.

Configuration
REQ-034 The watchdog SHALL be controlled by the macro MULTDIV_CTRL_WATCHDOG_EN.
REQ-035 With MULTDIV_CTRL_WATCHDOG_EN defined:
- A 6-bit RUN-cycle counter SHALL clear on entry to LOAD.
- If RUN lasts 40 cycles without c_end, the block SHALL enter DONE with exception=1 and timeout=1.
REQ-036 With MULTDIV_CTRL_WATCHDOG_EN undefined:
- The watchdog counter SHALL be absent and timeout SHALL be tied to 0.
- RUN SHALL wait for c_end indefinitely.

Verification
REQ-037 Multiply: ctrl_mult pulse at edge 0 with a real counter attached -> load in cycle 1, step_en in cycles 2..33, ct 0..31, first_step in cycle 2 only, result_rdy=1 and exception=0 in cycle 34, is_div=0.
REQ-038 Divide by zero: ctrl_div=1 and div_zero=1 at edge 0 -> result_rdy=1, exception=1 and is_div=1 in cycle 1, no load, no step_en.
REQ-039 Both ctrl_mult and ctrl_div high at edge 0 -> result_rdy=1 and exception=1 in cycle 1; busy stays 0.
REQ-040 Abort: ctrl_mult at edge 0, then ctrl_div at edge 10 -> load in cycle 11, result_rdy only in cycle 44 with is_div=1, and exactly one result_rdy pulse.
REQ-041 Reset at edge 20 of an operation -> IDLE, busy=0, cnt_reset=1 next cycle, and no result_rdy.
REQ-042 Watchdog (macro defined): c_end held at 0 -> exception=1 and timeout=1 with result_rdy in cycle 42; with the macro undefined, busy stays high and timeout stays 0.

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Sequencer for a 32-step iterative multiply/divide datapath and its external step counter.
// Latency: start at edge T -> load in T+1, step_en T+2..T+33, result_rdy T+34; errors finish in T+1.
// No backpressure: a new start always wins and aborts any operation in flight.
// Optional watchdog on the RUN phase is built when MULTDIV_CTRL_WATCHDOG_EN is defined.
module multdiv_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_mult,
  input  logic       ctrl_div,
  input  logic       div_zero,
  input  logic [4:0] ct,
  input  logic       c_end,
  output logic       cnt_reset,
  output logic       load,
  output logic       step_en,
  output logic       first_step,
  output logic       is_div,
  output logic       busy,
  output logic       result_rdy,
  output logic       exception,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   is_div_nxt;
  logic   exc_nxt;
  logic   start;
  logic   both_req;
  logic   dz_err;
  logic   wd_expired;

  // Exactly one request is a start; both at once, or divide by zero, is an immediate error.
  assign start    = ctrl_mult ^ ctrl_div;
  assign both_req = ctrl_mult & ctrl_div;
  assign dz_err   = ctrl_div & ~ctrl_mult & div_zero;

`ifdef MULTDIV_CTRL_WATCHDOG_EN
  // Last RUN cycle index (0-based) before the watchdog gives up: 40 RUN cycles in total.
  localparam logic [5:0] WD_LAST = 6'd39;

  logic [5:0] wd_cnt;
  logic       to_nxt;

  // Count RUN cycles, restarting whenever a new operation is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state_nxt == LOAD) begin
      wd_cnt <= '0;
    end else if (state == RUN) begin
      wd_cnt <= wd_cnt + 6'd1;
    end
  end

  assign wd_expired = (state == RUN) && (wd_cnt == WD_LAST);
  // A timeout only stands if no normal finish and no new request arrive in the same cycle.
  assign to_nxt     = wd_expired & ~c_end & ~ctrl_mult & ~ctrl_div;

  // Timeout flag is live only for the DONE cycle it causes.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= to_nxt;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

  // State, latched operation and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      is_div    <= 1'b0;
      exception <= 1'b0;
    end else begin
      state     <= state_nxt;
      is_div    <= is_div_nxt;
      exception <= exc_nxt;
    end
  end

  // Next-state: requests override the current state; otherwise walk IDLE/LOAD/RUN/DONE.
  always_comb begin
    state_nxt  = state;
    is_div_nxt = is_div;
    exc_nxt    = 1'b0;
    if (both_req) begin
      state_nxt = DONE;
      exc_nxt   = 1'b1;
    end else if (dz_err) begin
      state_nxt  = DONE;
      exc_nxt    = 1'b1;
      is_div_nxt = 1'b1;
    end else if (start) begin
      state_nxt  = LOAD;
      is_div_nxt = ctrl_div;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: state_nxt = RUN;
        RUN: begin
          if (c_end) begin
            state_nxt = DONE;
          end else if (wd_expired) begin
            state_nxt = DONE;
            exc_nxt   = 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded purely from state and the counter value.
  always_comb begin
    cnt_reset  = (state != RUN);
    load       = (state == LOAD);
    step_en    = (state == RUN);
    first_step = (state == RUN) && (ct == 5'd0);
    busy       = (state == LOAD) || (state == RUN);
    result_rdy = (state == DONE);
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl with a 5-bit step counter model attached.
// Expected completions are queued on issue and checked when result_rdy appears.
// Cycle numbers follow the convention: start sampled at edge T, load in cycle T+1.
module tb_multdiv_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       ctrl_mult;
  logic       ctrl_div;
  logic       div_zero;
  logic [4:0] ct = '0;
  logic       c_end;
  logic       cnt_reset;
  logic       load;
  logic       step_en;
  logic       first_step;
  logic       is_div;
  logic       busy;
  logic       result_rdy;
  logic       exception;
  logic       timeout;

  int cyc       = 0;
  int checks    = 0;
  int failures  = 0;
  int cend_mode = 0;  // 0: real counter, 1: c_end forced low, 2: c_end forced high

  multdiv_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_mult  (ctrl_mult),
    .ctrl_div   (ctrl_div),
    .div_zero   (div_zero),
    .ct         (ct),
    .c_end      (c_end),
    .cnt_reset  (cnt_reset),
    .load       (load),
    .step_en    (step_en),
    .first_step (first_step),
    .is_div     (is_div),
    .busy       (busy),
    .result_rdy (result_rdy),
    .exception  (exception),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Edge index: after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // 32-step counter model driven by the DUT's cnt_reset.
  always @(posedge clk) begin
    if (cnt_reset) ct <= 5'd0;
    else           ct <= ct + 5'd1;
  end

  always_comb begin
    c_end = (ct == 5'd31);
    if (cend_mode == 1) c_end = 1'b0;
    if (cend_mode == 2) c_end = 1'b1;
  end

  typedef struct {
    int rdy;
    bit isd;
    bit exc;
    bit to;
    int loads;
    int steps;
    int busy_n;
    int firsts;
    int last_load;
  } exp_t;

  typedef struct {
    bit m;
    bit d;
    bit z;
    int lat;
    bit isd;
    bit exc;
    int loads;
    int steps;
    int busy_n;
    int firsts;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_load    = 0;
  int n_step    = 0;
  int n_first   = 0;
  int n_busy    = 0;
  int last_load = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; t is the edge that samples it.
  task automatic issue(input bit m, input bit d, input bit z, output int t);
    ctrl_mult = m;
    ctrl_div  = d;
    div_zero  = z;
    t = cyc + 1;
    tick();
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    div_zero  = 1'b0;
  endtask

  task automatic push_exp(input int rdy, input bit isd, input bit exc, input bit to,
                          input int loads, input int steps, input int busy_n,
                          input int firsts, input int ll);
    exp_t e;
    e.rdy = rdy; e.isd = isd; e.exc = exc; e.to = to;
    e.loads = loads; e.steps = steps; e.busy_n = busy_n;
    e.firsts = firsts; e.last_load = ll;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_wait_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
    tick();
  endtask

  // Monitor: per-operation activity counts, invariants, and scoreboard pop on result_rdy.
  always @(negedge clk) begin
    if (reset) begin
      n_load = 0; n_step = 0; n_first = 0; n_busy = 0; last_load = 0;
    end else begin
      if (load) begin
        n_load++;
        last_load = cyc + 1;
      end
      if (step_en)    n_step++;
      if (first_step) n_first++;
      if (busy)       n_busy++;
      if (exception) chk("exception_without_rdy", int'(result_rdy), 1);
      if (timeout)   chk("timeout_without_exception", int'(exception), 1);
      if (result_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_result_rdy", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rdy_cycle", cyc + 1, mon_e.rdy);
          chk("is_div", int'(is_div), int'(mon_e.isd));
          chk("exception", int'(exception), int'(mon_e.exc));
          chk("timeout", int'(timeout), int'(mon_e.to));
          chk("load_count", n_load, mon_e.loads);
          chk("step_count", n_step, mon_e.steps);
          chk("busy_count", n_busy, mon_e.busy_n);
          chk("first_step_count", n_first, mon_e.firsts);
          chk("last_load_cycle", last_load, mon_e.last_load);
        end
        n_load = 0; n_step = 0; n_first = 0; n_busy = 0; last_load = 0;
      end
    end
  end

  initial begin
    vec_t tbl[6];
    int   t;
    int   t2;

    //           m  d  z  lat isd exc loads steps busy firsts
    tbl[0] = '{1, 0, 0, 34, 0,  0,  1,    32,   33,  1};  // multiply
    tbl[1] = '{1, 1, 0, 1,  0,  1,  0,    0,    0,   0};  // both: is_div keeps 0
    tbl[2] = '{0, 1, 0, 34, 1,  0,  1,    32,   33,  1};  // divide
    tbl[3] = '{1, 1, 1, 1,  1,  1,  0,    0,    0,   0};  // both: is_div keeps 1
    tbl[4] = '{0, 1, 1, 1,  1,  1,  0,    0,    0,   0};  // divide by zero
    tbl[5] = '{1, 0, 1, 34, 0,  0,  1,    32,   33,  1};  // multiply ignores div_zero

    reset = 1'b1; ctrl_mult = 1'b0; ctrl_div = 1'b0; div_zero = 1'b0;
    tick();
    tick();
    chk("reset_busy",       int'(busy),       0);
    chk("reset_cnt_reset",  int'(cnt_reset),  1);
    chk("reset_load",       int'(load),       0);
    chk("reset_step_en",    int'(step_en),    0);
    chk("reset_result_rdy", int'(result_rdy), 0);
    chk("reset_exception",  int'(exception),  0);
    chk("reset_timeout",    int'(timeout),    0);
    chk("reset_is_div",     int'(is_div),     0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].m, tbl[i].d, tbl[i].z, t);
      push_exp(t + tbl[i].lat, tbl[i].isd, tbl[i].exc, 1'b0, tbl[i].loads,
               tbl[i].steps, tbl[i].busy_n, tbl[i].firsts,
               (tbl[i].loads != 0) ? t + 1 : 0);
      wait_idle();
    end

    // Abort: multiply at edge T, divide at edge T+10.
    issue(1'b1, 1'b0, 1'b0, t);
    repeat (9) tick();
    issue(1'b0, 1'b1, 1'b0, t2);
    chk("abort_edge", t2, t + 10);
    push_exp(t + 44, 1'b1, 1'b0, 1'b0, 2, 41, 43, 2, t + 11);
    wait_idle();

    // Start sampled in DONE goes straight to LOAD; both operations complete.
    issue(1'b1, 1'b0, 1'b0, t);
    push_exp(t + 34, 1'b0, 1'b0, 1'b0, 1, 32, 33, 1, t + 1);
    repeat (33) tick();
    issue(1'b0, 1'b1, 1'b0, t2);
    push_exp(t2 + 34, 1'b1, 1'b0, 1'b0, 1, 32, 33, 1, t2 + 1);
    wait_idle();

    // Reset sampled at edge T+20 of a divide: abandoned, no completion.
    issue(1'b0, 1'b1, 1'b0, t);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy",       int'(busy),       0);
    chk("rst_mid_cnt_reset",  int'(cnt_reset),  1);
    chk("rst_mid_result_rdy", int'(result_rdy), 0);
    chk("rst_mid_is_div",     int'(is_div),     0);
    repeat (40) tick();

    // c_end while idle must not start or finish anything.
    cend_mode = 2;
    repeat (5) tick();
    chk("cend_idle_busy", int'(busy), 0);
    cend_mode = 0;
    tick();

    // Watchdog: c_end never arrives.
    cend_mode = 1;
    issue(1'b1, 1'b0, 1'b0, t);
`ifdef MULTDIV_CTRL_WATCHDOG_EN
    push_exp(t + 42, 1'b0, 1'b1, 1'b1, 1, 40, 41, 2, t + 1);
    wait_idle();
    cend_mode = 0;
`else
    repeat (60) tick();
    chk("no_wd_busy",    int'(busy),    1);
    chk("no_wd_timeout", int'(timeout), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cend_mode = 0;
    chk("no_wd_recover_busy", int'(busy), 0);
    tick();
`endif

    // One more plain multiply after all the corner cases.
    issue(1'b1, 1'b0, 1'b0, t);
    push_exp(t + 34, 1'b0, 1'b0, 1'b0, 1, 32, 33, 1, t + 1);
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
